// File: rtl/dcache_responder_if.sv
// Datapath/memory-side bundle for dcache_responder. The cache uses the slave modport and the
// datapath, arbiter or testbench uses the master modport.
interface dcache_responder_if;
  // Datapath side: the request (dmemREN/dmemWEN, with qualifiers and address held stable) stays
  // asserted until a cycle where dhit=1, and completes on the rising edge that ends that cycle.
  // Memory side: mem_dREN/mem_dWEN stay high with a stable mem_daddr/mem_dstore, and the transfer
  // completes on the rising edge that ends a cycle with mem_dwait=0.
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic [31:0] mem_daddr;
  logic [31:0] mem_dstore;
  logic        mem_dwait;
  logic [31:0] mem_dload;

  modport slave (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, mem_dwait, mem_dload,
    output dhit, dmemload, flushed, mem_dREN, mem_dWEN, mem_daddr, mem_dstore
  );

  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, mem_dwait, mem_dload,
    input  dhit, dmemload, flushed, mem_dREN, mem_dWEN, mem_daddr, mem_dstore
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, one-word-per-frame data cache with an LL/SC link register and a
// flush-on-halt pass. Defining HIT_COUNT_EN adds the saturating hit/miss counters.
module dcache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  dcache_responder_if.slave   bus,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [2:0]          state_dbg
);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       data_q [SETS];
  logic [31:0]       data_d [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic              link_valid_q, link_valid_d;
  logic [29:0]       link_addr_q, link_addr_d;
  logic [29:0]       miss_addr_q, miss_addr_d;
  logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic              req, is_wr, is_ll, is_sc, link_match, sc_fail, hit, svc, miss, flush_dirty;
  logic              unused_addr_lsb;

  assign req_idx     = bus.dmemaddr[IDX_W+1:2];
  assign req_tag     = bus.dmemaddr[31:IDX_W+2];
  assign miss_idx    = miss_addr_q[IDX_W-1:0];
  assign miss_tag    = miss_addr_q[29:IDX_W];
  assign req         = bus.dmemREN | bus.dmemWEN;
  assign is_wr       = bus.dmemWEN;
  assign is_ll       = bus.dmemREN & ~bus.dmemWEN & bus.datomic;
  assign is_sc       = bus.dmemWEN & bus.datomic;
  assign link_match  = link_valid_q && (link_addr_q == bus.dmemaddr[31:2]);
  // A failing SC answers at once and never touches the array or memory.
  assign sc_fail     = is_sc & ~link_match;
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign svc         = req && !sc_fail && hit;
  assign miss        = req && !sc_fail && !hit;
  assign flush_dirty = dirty_q[flush_idx_q];
  assign state_dbg   = state_q;
  assign unused_addr_lsb = ^bus.dmemaddr[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      miss_addr_q  <= '0;
      flush_idx_q  <= '0;
      for (int i = 0; i < SETS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      miss_addr_q  <= miss_addr_d;
      flush_idx_q  <= flush_idx_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss)          state_d = dirty_q[req_idx] ? S_WB : S_FILL;
        else if (bus.halt) state_d = S_FLUSH;
      end
      // A request dropped during write-back skips the fill.
      S_WB:    if (!bus.mem_dwait) state_d = req ? S_FILL : S_IDLE;
      S_FILL:  if (!bus.mem_dwait) state_d = S_IDLE;
      S_FLUSH: begin
        if (flush_idx_q == IDX_W'(SETS - 1) && (!flush_dirty || !bus.mem_dwait))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d       = data_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    miss_addr_d  = miss_addr_q;
    flush_idx_d  = flush_idx_q;
    case (state_q)
      S_IDLE: begin
        if (sc_fail && req) link_valid_d = 1'b0;
        if (svc) begin
          if (is_wr) begin
            data_d[req_idx]  = bus.dmemstore;
            dirty_d[req_idx] = 1'b1;
            if (is_sc || link_match) link_valid_d = 1'b0;
          end
          if (is_ll) begin
            link_addr_d  = bus.dmemaddr[31:2];
            link_valid_d = 1'b1;
          end
        end
        if (miss) miss_addr_d = bus.dmemaddr[31:2];
        if (!miss && bus.halt) flush_idx_d = '0;
      end
      S_WB: if (!bus.mem_dwait) dirty_d[miss_idx] = 1'b0;
      S_FILL: begin
        if (!bus.mem_dwait) begin
          data_d[miss_idx]  = bus.mem_dload;
          tag_d[miss_idx]   = miss_tag;
          valid_d[miss_idx] = 1'b1;
          dirty_d[miss_idx] = 1'b0;
        end
      end
      S_FLUSH: begin
        if (!flush_dirty) begin
          flush_idx_d = flush_idx_q + IDX_W'(1);
        end else if (!bus.mem_dwait) begin
          dirty_d[flush_idx_q] = 1'b0;
          flush_idx_d          = flush_idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.dhit       = 1'b0;
    bus.dmemload   = '0;
    bus.flushed    = 1'b0;
    bus.mem_dREN   = 1'b0;
    bus.mem_dWEN   = 1'b0;
    bus.mem_daddr  = '0;
    bus.mem_dstore = '0;
    case (state_q)
      S_IDLE: begin
        if (req && sc_fail) begin
          bus.dhit = 1'b1;
        end else if (svc) begin
          bus.dhit     = 1'b1;
          bus.dmemload = is_sc ? 32'd1 : (is_wr ? 32'd0 : data_q[req_idx]);
        end
      end
      S_WB: begin
        bus.mem_dWEN   = 1'b1;
        bus.mem_daddr  = {tag_q[miss_idx], miss_idx, 2'b00};
        bus.mem_dstore = data_q[miss_idx];
      end
      S_FILL: begin
        bus.mem_dREN  = 1'b1;
        bus.mem_daddr = {miss_addr_q, 2'b00};
      end
      S_FLUSH: begin
        if (flush_dirty) begin
          bus.mem_dWEN   = 1'b1;
          bus.mem_daddr  = {tag_q[flush_idx_q], flush_idx_q, 2'b00};
          bus.mem_dstore = data_q[flush_idx_q];
        end
      end
      S_DONE: bus.flushed = 1'b1;
      default: ;
    endcase
  end

`ifdef HIT_COUNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE) begin
      if (svc && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_d  = hit_cnt_q + 32'd1;
      if (miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: a latency-programmable memory model plus queues of expected
// load data, fill addresses and write-backs that are popped as the DUT produces them.
module tb_dcache_responder;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] hit_count, miss_count;
  logic [2:0]  state_dbg;

  always #5 CLK = ~CLK;

  dcache_responder_if bus ();

  dcache_responder dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .state_dbg  (state_dbg)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd_q[$];
  logic [63:0] exp_wr_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          lat = 3;
  int          cnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          lc;
  int          rd0, wr0;
  logic        saw_dhit;
  logic [31:0] v1, v2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'hBEEF};
  endfunction

  // Memory model: busy for `lat` cycles of a held strobe, done on the next.
  assign bus.mem_dwait = !((bus.mem_dREN || bus.mem_dWEN) && cnt >= lat);

  always @(posedge CLK) begin
    if (RST) cnt <= 0;
    else if ((bus.mem_dREN || bus.mem_dWEN) && !bus.mem_dwait) cnt <= 0;
    else if (bus.mem_dREN || bus.mem_dWEN) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always @(negedge CLK) begin
    if (bus.mem_dREN && bus.mem_dWEN) chk("rd_wr_exclusive", {bus.mem_dREN, bus.mem_dWEN}, 2'b00);
    if (!RST && bus.mem_dREN && !bus.mem_dwait) begin
      n_rd++;
      chk("fill_expected", exp_rd_q.size() > 0, 1);
      if (exp_rd_q.size() > 0) chk("fill_addr", bus.mem_daddr, exp_rd_q.pop_front());
    end
    if (!RST && bus.mem_dWEN && !bus.mem_dwait) begin
      n_wr++;
      chk("wb_expected", exp_wr_q.size() > 0, 1);
      if (exp_wr_q.size() > 0) chk("wb_addr_data", {bus.mem_daddr, bus.mem_dstore}, exp_wr_q.pop_front());
      mem_model[bus.mem_daddr] = bus.mem_dstore;
    end
    bus.mem_dload = mem_rd(bus.mem_daddr);
  end

  // Called at a falling edge; holds the request until dhit, then drops it one cycle later.
  task automatic do_req(input string tag, input logic ren, input logic wen, input logic at,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic chk_load, input logic [31:0] exp_load, output int lat_cyc);
    if (chk_load) exp_q.push_back(exp_load);
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.datomic   = at;
    bus.dmemaddr  = addr;
    bus.dmemstore = data;
    lat_cyc = 0;
    #1;
    while (!bus.dhit && lat_cyc < 300) begin
      @(negedge CLK);
      #1;
      lat_cyc++;
    end
    if (!bus.dhit) begin
      chk({tag, "_timeout"}, bus.dhit, 1'b1);
      if (chk_load) void'(exp_q.pop_back());
    end else if (chk_load) begin
      chk(tag, bus.dmemload, exp_q.pop_front());
    end
    @(negedge CLK);
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.datomic = 1'b0;
  endtask

  initial begin
    bus.dmemREN = 0; bus.dmemWEN = 0; bus.datomic = 0; bus.dmemaddr = 0;
    bus.dmemstore = 0; bus.halt = 0; bus.mem_dload = 0;
    mem_model[32'h40]  = 32'hDEAD_BEEF;
    mem_model[32'h440] = 32'h0440_CAFE;
    mem_model[32'h80]  = 32'h8080_0000;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_dhit", bus.dhit, 0);
    chk("rst_flushed", bus.flushed, 0);
    chk("rst_strobes", {bus.mem_dREN, bus.mem_dWEN}, 0);
    chk("rst_buses", {bus.dmemload, bus.mem_daddr, bus.mem_dstore}, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge CLK);

    // Cold read: fill only
    exp_rd_q.push_back(32'h40);
    do_req("t1_cold_read", 1, 0, 0, 32'h40, 0, 1, 32'hDEAD_BEEF, lc);
    chk("t1_counts", {n_rd, n_wr}, {32'd1, 32'd0});

    // Write hit then conflicting read: write-back then fill
    do_req("t2_write", 0, 1, 0, 32'h40, 32'h1234, 0, 0, lc);
    chk("t2_write_latency", lc, 0);
    exp_wr_q.push_back({32'h40, 32'h1234});
    exp_rd_q.push_back(32'h440);
    lat = $urandom_range(0, 3);
    do_req("t2_conflict_read", 1, 0, 0, 32'h440, 0, 1, 32'h0440_CAFE, lc);
    exp_rd_q.push_back(32'h40);
    do_req("t2_refetch", 1, 0, 0, 32'h40, 0, 1, 32'h1234, lc);

    // LL/SC success then stale SC
    exp_rd_q.push_back(32'h80);
    do_req("t3_ll", 1, 0, 1, 32'h80, 0, 1, 32'h8080_0000, lc);
    do_req("t3_sc_ok", 0, 1, 1, 32'h80, 32'd5, 1, 32'd1, lc);
    do_req("t3_read5", 1, 0, 0, 32'h80, 0, 1, 32'd5, lc);
    do_req("t3_sc_again", 0, 1, 1, 32'h80, 32'd7, 1, 32'd0, lc);
    do_req("t3_read_unchg", 1, 0, 0, 32'h80, 0, 1, 32'd5, lc);

    // Plain store breaks the link; SC without link answers at once
    do_req("t4_ll", 1, 0, 1, 32'h80, 0, 1, 32'd5, lc);
    do_req("t4_sw", 0, 1, 0, 32'h80, 32'd9, 0, 0, lc);
    do_req("t4_sc_broken", 0, 1, 1, 32'h80, 32'd11, 1, 32'd0, lc);
    do_req("t4_read9", 1, 0, 0, 32'h80, 0, 1, 32'd9, lc);
    rd0 = n_rd; wr0 = n_wr;
    do_req("t4_sc_nolink", 0, 1, 1, 32'h84, 32'd3, 1, 32'd0, lc);
    chk("t4_sc_latency", lc, 0);
    chk("t4_no_mem", {n_rd - rd0, n_wr - wr0}, 0);

    // Reset during a stalled write-back
    lat = 1000;
    bus.dmemREN = 1; bus.dmemaddr = 32'h480;
    for (int i = 0; i < 20 && !bus.mem_dWEN; i++) begin
      @(negedge CLK);
      #1;
    end
    chk("t6_wb_seen", {bus.mem_dWEN, bus.mem_daddr, bus.mem_dstore}, {1'b1, 32'h80, 32'd9});
    RST = 1'b1;
    bus.dmemREN = 0;
    @(negedge CLK);
    #1;
    chk("t6_after_rst", {bus.mem_dWEN, bus.mem_dREN, state_dbg}, 0);
    RST = 1'b0;
    lat = 2;
    @(negedge CLK);
    rd0 = n_rd;
    exp_rd_q.push_back(32'h80);
    do_req("t6_now_miss", 1, 0, 0, 32'h80, 0, 1, 32'h8080_0000, lc);
    chk("t6_fill_count", n_rd - rd0, 1);

    // Flush on halt: dirty idx 2 and 7 only
    lat = $urandom_range(0, 3);
    v1 = $urandom; v2 = $urandom;
    exp_rd_q.push_back(32'h08);
    do_req("t5_w2", 0, 1, 0, 32'h08, v1, 0, 0, lc);
    exp_rd_q.push_back(32'h1C);
    do_req("t5_w7", 0, 1, 0, 32'h1C, v2, 0, 0, lc);
    exp_wr_q.push_back({32'h08, v1});
    exp_wr_q.push_back({32'h1C, v2});
    wr0 = n_wr;
    saw_dhit = 0;
    bus.halt = 1;
    @(negedge CLK);
    bus.dmemREN = 1; bus.dmemaddr = 32'h08;
    for (int i = 0; i < 500 && !bus.flushed; i++) begin
      @(negedge CLK);
      #1;
      if (bus.dhit) saw_dhit = 1;
    end
    chk("t5_flushed", bus.flushed, 1);
    chk("t5_wb_count", n_wr - wr0, 2);
    chk("t5_wb_pending", exp_wr_q.size(), 0);
    chk("t5_no_dhit", saw_dhit, 0);
    repeat (3) @(negedge CLK);
    #1;
    chk("t5_done_sticky", {bus.flushed, bus.dhit, state_dbg}, {1'b1, 1'b0, 3'd4});
    chk("t5_mem_idx7", mem_model[32'h1C], v2);
    bus.dmemREN = 0;
`ifndef HIT_COUNT_EN
    chk("counters_tied", {hit_count, miss_count}, 0);
`endif
    chk("exp_q_drained", exp_q.size() + exp_rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
